// File: rtl/pickup_pkg.sv
// Shared types and width helpers for the pickup sprite and its neighbours.
package pickup_pkg;
    typedef enum logic [1:0] {IDLE, ACTIVE, BLINK} pickup_state_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int COORD_W  = 10;
    localparam int SUM_W    = COORD_W + 1;   // bounds math carries into bit 10 near x = 1023

    // Counter width that still yields a 1-bit field for degenerate sizes.
    function automatic int cw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/pickup_sprite_if.sv
// Spawn/hit control, pixel query and status bus between game logic and the pickup sprite.
interface pickup_sprite_if;
    import pickup_pkg::*;

    logic               spawn;
    logic [COORD_W-1:0] Spawn_X, Spawn_Y;
    logic               hit;
    logic [COORD_W-1:0] DrawX, DrawY;
    logic               is_pickup;
    logic               active;
    logic               collected;
    logic [COORD_W-1:0] Pos_X, Pos_Y;

    modport master (output spawn, Spawn_X, Spawn_Y, hit, DrawX, DrawY,
                    input  is_pickup, active, collected, Pos_X, Pos_Y);
    modport slave  (input  spawn, Spawn_X, Spawn_Y, hit, DrawX, DrawY,
                    output is_pickup, active, collected, Pos_X, Pos_Y);
endinterface

// File: rtl/pickup_sprite_rom.sv
// Combinational bitmap: a diamond centred in the cell, shrinking by one step per frame.
module pickup_sprite_rom
    import pickup_pkg::*;
#(
    parameter int SIZE   = 16,
    parameter int FRAMES = 2
) (
    input  logic [cw(FRAMES)-1:0] frame_idx,
    input  logic [cw(SIZE)-1:0]   row,
    output logic [SIZE-1:0]       row_bits
);
    // Opaque where the doubled Manhattan distance to the centre is within SIZE - 2*frame.
    always_comb begin : rom_lut
        int dr;
        int dc;
        row_bits = '0;
        dr = 2 * int'(row) - (SIZE - 1);
        if (dr < 0) dr = -dr;
        for (int c = 0; c < SIZE; c++) begin
            dc = 2 * c - (SIZE - 1);
            if (dc < 0) dc = -dc;
            row_bits[SIZE-1-c] = (dr + dc <= SIZE - 2 * int'(frame_idx));
        end
    end
endmodule

// File: rtl/pickup_sprite.sv
// Time-limited animated pickup: spawn/expire/collect FSM, blink phase and per-pixel hit test.
module pickup_sprite
    import pickup_pkg::*;
#(
    parameter int SIZE         = 16,
    parameter int SCALE        = 1,
    parameter int FRAMES       = 2,
    parameter int ANIM_DIV     = 15,
    parameter int LIFETIME     = 600,
    parameter int BLINK_FRAMES = 120,
    parameter int BLINK_PERIOD = 8
) (
    input logic            Clk,
    input logic            Reset,
    input logic            frame_clk,
    pickup_sprite_if.slave bus
);
    localparam int LIFE_W = cw(LIFETIME + 1);
    localparam int ANIM_W = cw(ANIM_DIV);
    localparam int FRM_W  = cw(FRAMES);
    localparam int IDX_W  = cw(SIZE);
    localparam int BLK_W  = cw(BLINK_PERIOD);
    localparam int SHIFT  = (SCALE == 4) ? 2 : (SCALE == 2) ? 1 : 0;
    localparam int SPAN   = SIZE * SCALE;

    pickup_state_t      state, state_n;
    logic [LIFE_W-1:0]  life, life_n;
    logic [ANIM_W-1:0]  anim, anim_n;
    logic [FRM_W-1:0]   frame_idx, frame_n;
    logic [BLK_W-1:0]   blink_cnt, blink_n;
    logic               vis, vis_n;
    logic [COORD_W-1:0] pos_x, pos_y, pos_x_n, pos_y_n;
    logic               collected_q, collected_n;
    logic               fclk_q;
    logic               tick;

    assign tick = frame_clk & ~fclk_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            life        <= '0;
            anim        <= '0;
            frame_idx   <= '0;
            blink_cnt   <= '0;
            vis         <= 1'b0;
            pos_x       <= '0;
            pos_y       <= '0;
            collected_q <= 1'b0;
            fclk_q      <= 1'b0;
        end else begin
            state       <= state_n;
            life        <= life_n;
            anim        <= anim_n;
            frame_idx   <= frame_n;
            blink_cnt   <= blink_n;
            vis         <= vis_n;
            pos_x       <= pos_x_n;
            pos_y       <= pos_y_n;
            collected_q <= collected_n;
            fclk_q      <= frame_clk;
        end
    end

    always_comb begin
        state_n     = state;
        life_n      = life;
        anim_n      = anim;
        frame_n     = frame_idx;
        blink_n     = blink_cnt;
        vis_n       = vis;
        pos_x_n     = pos_x;
        pos_y_n     = pos_y;
        collected_n = 1'b0;
        case (state)
            IDLE: begin
                if (bus.spawn) begin
                    pos_x_n = bus.Spawn_X;
                    pos_y_n = bus.Spawn_Y;
                    life_n  = LIFE_W'(LIFETIME);
                    anim_n  = '0;
                    frame_n = '0;
                    blink_n = '0;
                    vis_n   = 1'b1;
                    state_n = ACTIVE;
                end
            end
            ACTIVE, BLINK: begin
                // A hit on the same edge as the final tick still counts as a collection.
                if (bus.hit) begin
                    collected_n = 1'b1;
                    state_n     = IDLE;
                end else if (tick) begin
                    life_n = life - 1'b1;
                    if (anim == ANIM_W'(ANIM_DIV - 1)) begin
                        anim_n  = '0;
                        frame_n = (frame_idx == FRM_W'(FRAMES - 1)) ? '0 : frame_idx + 1'b1;
                    end else begin
                        anim_n = anim + 1'b1;
                    end
                    if (state == BLINK) begin
                        if (blink_cnt == BLK_W'(BLINK_PERIOD - 1)) begin
                            blink_n = '0;
                            vis_n   = ~vis;
                        end else begin
                            blink_n = blink_cnt + 1'b1;
                        end
                    end
                    if (life_n == '0) begin
                        state_n = IDLE;
                    end else if (state == ACTIVE && life_n == LIFE_W'(BLINK_FRAMES)) begin
                        state_n = BLINK;
                        blink_n = '0;
                        vis_n   = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    logic [SUM_W-1:0] dx, dy;
    logic             in_x, in_y, show;
    logic [IDX_W-1:0] col, row, col_r;
    logic [SIZE-1:0]  row_bits;

    // The 11-bit offsets double as the upper-bound test, so nothing wraps past x = 1023.
    assign dx    = {1'b0, bus.DrawX} - {1'b0, pos_x};
    assign dy    = {1'b0, bus.DrawY} - {1'b0, pos_y};
    assign in_x  = (bus.DrawX >= pos_x) && (dx < SUM_W'(SPAN));
    assign in_y  = (bus.DrawY >= pos_y) && (dy < SUM_W'(SPAN));
    assign col   = dx[IDX_W+SHIFT-1:SHIFT];
    assign row   = dy[IDX_W+SHIFT-1:SHIFT];
    assign col_r = ~col;
    assign show  = (state == ACTIVE) || (state == BLINK && vis);

    pickup_sprite_rom #(.SIZE(SIZE), .FRAMES(FRAMES)) u_rom (
        .frame_idx (frame_idx),
        .row       (row),
        .row_bits  (row_bits)
    );

    assign bus.is_pickup = show && in_x && in_y && row_bits[col_r];
    assign bus.active    = (state != IDLE);
    assign bus.collected = collected_q;
    assign bus.Pos_X     = pos_x;
    assign bus.Pos_Y     = pos_y;
endmodule

// File: tb/tb_pickup_sprite.sv
// Scoreboard bench: a lifetime-level reference model queues expected outputs, a negedge monitor compares.
module tb_pickup_sprite;
    import pickup_pkg::*;

    localparam int SIZE         = 16;
    localparam int SCALE        = 2;
    localparam int FRAMES       = 2;
    localparam int ANIM_DIV     = 3;
    localparam int LIFETIME     = 20;
    localparam int BLINK_FRAMES = 8;
    localparam int BLINK_PERIOD = 2;
    localparam int SPAN         = SIZE * SCALE;

    logic Clk = 1'b0;
    logic Reset;
    logic frame_clk;
    pickup_sprite_if bus();

    pickup_sprite #(
        .SIZE(SIZE), .SCALE(SCALE), .FRAMES(FRAMES), .ANIM_DIV(ANIM_DIV),
        .LIFETIME(LIFETIME), .BLINK_FRAMES(BLINK_FRAMES), .BLINK_PERIOD(BLINK_PERIOD)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .bus       (bus)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic       active;
        logic       collected;
        logic       is_pickup;
        logic [9:0] px;
        logic [9:0] py;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    // Reference state: pickup alive, ticks left, ticks since spawn, position.
    int m_alive = 0, m_life = 0, m_ticks = 0, m_px = 0, m_py = 0, m_coll = 0, m_fprev = 0;
    bit p_rst = 1'b1, p_sp = 1'b0, p_ht = 1'b0, p_fc = 1'b0;
    int p_sx = 0, p_sy = 0;

    // Artwork: diamond around the cell centre, one step smaller per animation frame.
    function automatic bit bitmap(input int f, input int r, input int c);
        int dr, dc;
        dr = 2 * r - (SIZE - 1);
        dc = 2 * c - (SIZE - 1);
        if (dr < 0) dr = -dr;
        if (dc < 0) dc = -dc;
        return (dr + dc) <= (SIZE - 2 * f);
    endfunction

    function automatic bit exp_pix(input int x, input int y);
        int f;
        if (m_alive == 0) return 1'b0;
        if (m_life <= BLINK_FRAMES && (((BLINK_FRAMES - m_life) / BLINK_PERIOD) % 2) == 1) return 1'b0;
        if (x < m_px || x >= m_px + SPAN) return 1'b0;
        if (y < m_py || y >= m_py + SPAN) return 1'b0;
        f = (m_ticks / ANIM_DIV) % FRAMES;
        return bitmap(f, (y - m_py) / SCALE, (x - m_px) / SCALE);
    endfunction

    task automatic cycle(input bit rst, input bit sp, input bit ht, input bit fc,
                         input int sx, input int sy, input int x, input int y);
        exp_t e;
        bit tick;
        @(posedge Clk);
        if (p_rst) begin
            m_alive = 0; m_coll = 0; m_px = 0; m_py = 0; m_fprev = 0; m_life = 0; m_ticks = 0;
        end else begin
            tick    = p_fc && (m_fprev == 0);
            m_fprev = p_fc;
            m_coll  = 0;
            if (m_alive == 0) begin
                if (p_sp) begin
                    m_alive = 1; m_life = LIFETIME; m_ticks = 0; m_px = p_sx; m_py = p_sy;
                end
            end else if (p_ht) begin
                m_coll = 1; m_alive = 0;
            end else if (tick) begin
                m_life--; m_ticks++;
                if (m_life == 0) m_alive = 0;
            end
        end
        #1;
        Reset = rst; bus.spawn = sp; bus.hit = ht; frame_clk = fc;
        bus.Spawn_X = 10'(sx); bus.Spawn_Y = 10'(sy);
        bus.DrawX = 10'(x); bus.DrawY = 10'(y);
        p_rst = rst; p_sp = sp; p_ht = ht; p_fc = fc; p_sx = sx & 1023; p_sy = sy & 1023;
        e.active    = (m_alive != 0);
        e.collected = (m_coll != 0);
        e.is_pickup = exp_pix(x & 1023, y & 1023);
        e.px        = 10'(m_px);
        e.py        = 10'(m_py);
        sb.push_back(e);
    endtask

    task automatic ticks(input int n, input int x, input int y);
        for (int i = 0; i < n; i++) begin
            cycle(0, 0, 0, 1, 0, 0, x, y);
            cycle(0, 0, 0, 0, 0, 0, x, y);
        end
    endtask

    task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge Clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("active",    10'(bus.active),    10'(e.active));
                chk("collected", 10'(bus.collected), 10'(e.collected));
                chk("is_pickup", 10'(bus.is_pickup), 10'(e.is_pickup));
                chk("Pos_X",     bus.Pos_X,          e.px);
                chk("Pos_Y",     bus.Pos_Y,          e.py);
            end
        end
    end

    initial begin : stimulus
        int x;
        Reset = 1'b1; frame_clk = 1'b0; bus.spawn = 1'b0; bus.hit = 1'b0;
        bus.Spawn_X = '0; bus.Spawn_Y = '0; bus.DrawX = '0; bus.DrawY = '0;
        repeat (2) cycle(1, 0, 0, 0, 0, 0, 0, 0);

        // Spawn at (100,200) and sweep the whole footprint plus a margin.
        cycle(0, 1, 0, 0, 100, 200, 0, 0);
        for (int y = 198; y < 200 + SPAN + 2; y++)
            for (int xx = 98; xx < 100 + SPAN + 2; xx++)
                cycle(0, 0, 0, 0, 0, 0, xx, y);
        cycle(0, 1, 0, 0, 500, 500, 116, 216);          // re-spawn while alive is ignored

        // Hold hit for three cycles, then re-spawn elsewhere.
        repeat (3) cycle(0, 0, 1, 0, 0, 0, 116, 216);
        cycle(0, 1, 0, 0, 300, 300, 316, 316);
        repeat (2) cycle(0, 0, 0, 0, 0, 0, 316, 316);

        // Right-edge placement: no wrap into x = 0..9.
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 1010, 50, 0, 0);
        for (int y = 48; y < 54; y++) begin
            for (int xx = 1000; xx < 1024; xx++) cycle(0, 0, 0, 0, 0, 0, xx, y);
            for (int xx = 0; xx < 10; xx++) cycle(0, 0, 0, 0, 0, 0, xx, y);
        end

        // Full lifetime with blinking, watching the centre pixel; spawn mid-life ignored.
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 200, 100, 216, 116);
        ticks(10, 216, 116);
        cycle(0, 1, 0, 0, 600, 400, 216, 116);
        ticks(15, 216, 116);

        // Hit on the very tick that would expire the pickup.
        cycle(0, 1, 0, 0, 40, 40, 56, 56);
        ticks(19, 56, 56);
        cycle(0, 0, 1, 1, 0, 0, 56, 56);
        repeat (3) cycle(0, 0, 0, 0, 0, 0, 56, 56);

        // Reset while blinking.
        cycle(0, 1, 0, 0, 60, 70, 76, 86);
        ticks(14, 76, 86);
        cycle(1, 0, 0, 0, 0, 0, 76, 86);
        repeat (3) cycle(0, 0, 0, 0, 0, 0, 76, 86);

        // Randomised traffic, pixels biased toward the current footprint.
        for (int i = 0; i < 5000; i++) begin
            if ($urandom % 4 != 0) x = m_px + int'($urandom_range(0, SPAN + 3)) - 2;
            else x = int'($urandom % 1024);
            cycle(($urandom % 500) == 0, ($urandom % 8) == 0, ($urandom % 80) == 0,
                  ($urandom % 3) == 0, int'($urandom % 1024), int'($urandom % 1024),
                  x, m_py + int'($urandom_range(0, SPAN + 3)) - 2);
        end

        repeat (2) @(negedge Clk);
        #1;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
